// File: rtl/sram_ctrl.sv
// sram_ctrl: multi-cycle bridge between the MEM stage and a 32-bit
// asynchronous SRAM. Each op is latched in IDLE and run for WAIT_CYCLES+1
// ACCESS cycles. The FSM then parks in DONE until the pipeline is released.
// Optional macro SRAM_TURNAROUND_EN adds one idle TURN cycle after every store.
// This gives SRAMs with a write-recovery requirement time to settle.
`timescale 1ns/1ps
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ramOp_i,
    input  logic [31:0] ramAddr_i,
    input  logic [31:0] storeData_i,
    input  logic        hold_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o
);

    // MEM op encodings shared with the pipeline
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_TURN   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_n_q, be_n_d;
    logic [31:0] load_q, load_d;

    logic        op_is_store;
    logic [3:0]  be_sb;
    logic        unused_addr_bits;

    // Only bits 21:0 of the byte address reach the 1M-word SRAM.
    assign unused_addr_bits = ^ramAddr_i[31:22];

    assign op_is_store = (op_q == MEM_SB) || (op_q == MEM_SH) || (op_q == MEM_SW);
    assign be_sb       = ~(4'b0001 << ramAddr_i[1:0]);

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [3:0]  op,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            MEM_LB:  r = {{24{b[7]}}, b};
            MEM_LBU: r = {24'h0, b};
            MEM_LH:  r = {{16{h[15]}}, h};
            MEM_LHU: r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Next-state logic: latch the op in IDLE, count down ACCESS, park in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_n_d  = be_n_q;
        load_d  = load_q;
        case (state_q)
            S_IDLE: begin
                if (ramOp_i != MEM_NOP) begin
                    op_d    = ramOp_i;
                    lane_d  = ramAddr_i[1:0];
                    addr_d  = ramAddr_i[21:2];
                    cnt_d   = WAIT_INIT;
                    state_d = S_ACCESS;
                    case (ramOp_i)
                        MEM_SB: begin
                            wdata_d = {4{storeData_i[7:0]}};
                            be_n_d  = be_sb;
                        end
                        MEM_SH: begin
                            wdata_d = {2{storeData_i[15:0]}};
                            be_n_d  = ramAddr_i[1] ? 4'b0011 : 4'b1100;
                        end
                        MEM_SW: begin
                            wdata_d = storeData_i;
                            be_n_d  = 4'b0000;
                        end
                        default: begin
                            // loads read the whole word; lane select happens on capture
                            be_n_d  = 4'b0000;
                        end
                    endcase
                end
            end
            S_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    if (op_is_store) begin
`ifdef SRAM_TURNAROUND_EN
                        state_d = S_TURN;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        load_d  = load_extend(sram_rdata_i, op_q, lane_q);
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef SRAM_TURNAROUND_EN
            S_TURN: begin
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                // stay parked while frozen so the same op is not issued twice
                if (!hold_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            op_q    <= MEM_NOP;
            lane_q  <= 2'd0;
            addr_q  <= 20'd0;
            wdata_q <= 32'd0;
            be_n_q  <= 4'hF;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_n_q  <= be_n_d;
            load_q  <= load_d;
        end
    end

    // Strobes decode from the state register only, so they cannot glitch with
    // the address.
    assign sram_ce_n_o  = (state_q != S_ACCESS);
    assign sram_oe_n_o  = !((state_q == S_ACCESS) && !op_is_store);
    assign sram_we_n_o  = !((state_q == S_ACCESS) && op_is_store);
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_be_n_o  = be_n_q;
    assign load_data_o  = load_q;

    assign stall_o = !rst && (((state_q == S_IDLE) && (ramOp_i != MEM_NOP)) ||
                              (state_q == S_ACCESS) || (state_q == S_TURN));

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

- Multi-cycle controller between the MEM stage and the 32-bit external SRAM.
- Consumes the MEM stage's `ramOp_o`, `ramAddr_o` and `storeData_o`, and returns the extended load word on `load_data_o`, which feeds MEM's `load_data_i`.
- Drives the SRAM strobes through a small FSM.
- Holds the pipeline with `stall_o` until the access has resolved.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra SRAM access cycles beyond the first; legal range 0–7.

Ports:
- `clk` input 1: the single clock for the block.
- `rst` input 1: synchronous, active-high reset.
- `ramOp_i` input 4: memory op using the `defines.v` encodings `MEM_NOP`, `MEM_LB`, `MEM_LBU`, `MEM_LH`, `MEM_LHU`, `MEM_LW`, `MEM_SB`, `MEM_SH`, `MEM_SW`.
- `ramAddr_i` input 32: byte address.
- `storeData_i` input 32: store data; the operand sits in the low bits.
- `hold_i` input 1: pipeline is frozen by another stall source.
- `load_data_o` output 32: extended load result.
- `stall_o` output 1: request to freeze the pipeline.
- `sram_addr_o` output 20: word address.
- `sram_wdata_o` output 32: write data to the SRAM.
- `sram_rdata_i` input 32: read data from the SRAM.
- `sram_ce_n_o` output 1: chip enable, active low.
- `sram_oe_n_o` output 1: output enable, active low.
- `sram_we_n_o` output 1: write enable, active low.
- `sram_be_n_o` output 4: byte enables, active low; lane 0 is bits 7:0 (little-endian).

## Operation
States: IDLE, ACCESS, TURN (only when the macro is defined), DONE.

- **IDLE**
  - Idle when `ramOp_i == MEM_NOP`.
  - Any other op is latched at the clock edge: `sram_addr_o <= ramAddr_i[21:2]`, plus byte enables, write data and op.
  - Wait counter loads `WAIT_CYCLES`; next state is ACCESS.
- **ACCESS**
  - `ce_n = 0`. Loads drive `oe_n = 0`; stores drive `we_n = 0`.
  - Counter decrements each cycle.
  - When the counter is 0: loads capture `sram_rdata_i`, extend it and register it into `load_data_o`, then go to DONE. Stores go to DONE, or to TURN when the macro is defined.
- **DONE**
  - All strobes deasserted; `stall_o = 0`.
  - `hold_i = 1` keeps the FSM in DONE with `load_data_o` held. This prevents re-issuing the same op while the pipeline is frozen.
  - `hold_i = 0` moves the FSM to IDLE.
- **Load extension** (lane taken from `addr[1:0]`)
  - `LB`: byte, sign-extended. `LBU`: byte, zero-extended.
  - `LH` / `LHU`: halfword at `addr[1]`, sign- or zero-extended.
  - `LW`: full word.
- **Store lanes**
  - `SB`: `wdata = {4{b}}`; `be_n` has a 0 only in lane `addr[1:0]`.
  - `SH`: `wdata = {2{h}}`; `be_n` is `4'b1100` for `addr[1] = 0`, `4'b0011` for `addr[1] = 1`.
  - `SW`: `be_n = 4'b0000`.
  - Loads use `be_n = 4'b0000`.
- **Misalignment**
  - MEM squashes misaligned ops to `MEM_NOP`.
  - This block ignores the low address bits that are not needed for lane selection.
- **stall_o** is combinational: `!rst && ((state == IDLE && ramOp_i != MEM_NOP) || state == ACCESS || state == TURN)`.

## Timing
- **Reset values** (next edge with `rst = 1`): state IDLE, `ce_n/oe_n/we_n = 1`, `be_n = 4'hF`, `sram_addr_o = 0`, `sram_wdata_o = 0`, `load_data_o = 0`, `stall_o = 0`.
- **Reset mid-access**: strobes release at the reset edge and the access is abandoned; no partial data reaches `load_data_o`.
- **Load latency**: op in IDLE at cycle 0, ACCESS for cycles 1..`WAIT_CYCLES`+1, DONE at cycle `WAIT_CYCLES`+2.
  - `stall_o` is high for `WAIT_CYCLES`+2 cycles.
  - Result is valid from the DONE cycle onward.
- **Store latency**: same as a load, plus one TURN cycle when the macro is defined.
- **Back-to-back ops**: each op passes through DONE then IDLE. The minimum spacing is `WAIT_CYCLES`+3 cycles.
- **Signal stability**:
  - Address, write data and `be_n` are registered and stable for the whole ACCESS window.
  - `we_n` never toggles while the address changes.

## Configuration
- `SRAM_TURNAROUND_EN` defined: after every store, one TURN cycle with `ce_n = 1`, all strobes high and `stall_o = 1` before DONE. This provides bus turnaround for SRAMs with a write-recovery requirement.
- Undefined: stores go from ACCESS straight to DONE, and TURN is not synthesised.

## Test plan
- **Reset**: assert `rst` during an LW in ACCESS with `WAIT_CYCLES = 1` -> next edge gives `ce_n = oe_n = 1`, `be_n = F`, state IDLE, `load_data_o = 0`; after release, a NOP input keeps `stall_o = 0`.
- **LW**: `ramAddr_i = 0x00000010`, `sram_rdata_i = 0xDEADBEEF` -> `sram_addr_o = 0x4`, `stall_o` high 3 cycles, `load_data_o = 0xDEADBEEF` in DONE.
- **LB/LBU**: `addr = 0x13`, `rdata = 0x80FF1234` -> LB gives `0xFFFFFF80`; LBU gives `0x00000080`.
- **LH**: `addr = 0x2`, same rdata -> `0xFFFF80FF`; LHU gives `0x000080FF`.
- **SB**: `addr = 0x21`, `storeData_i = 0x000000A5` -> `wdata = 0xA5A5A5A5`, `be_n = 4'b1101`, `we_n` low exactly `WAIT_CYCLES`+1 cycles. With `SRAM_TURNAROUND_EN`, `stall_o` stays high one extra cycle with all strobes high.
- **Hold**: `hold_i = 1` for 4 cycles in DONE after an LW -> no second `ce_n` assertion, `load_data_o` unchanged. After `hold_i` falls, IDLE accepts the next op.
